// File: rtl/sram_track_sched.sv
// sram_track_sched: per-frame SRAM scheduler for two-track playback (read T1, read T2, optional overdub write).
module sram_track_sched #(
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int ACC_CYC = 2
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iFRAME,
  input  logic          iRUN,
  input  logic          iLOOP,
  input  logic          iREC_EN,
  input  logic          iREC_TRK,
  input  logic [DW-1:0] iREC_DATA,
  input  logic [AW-1:0] iT1_BASE,
  input  logic [AW-1:0] iT2_BASE,
  input  logic [AW-1:0] iT1_LEN,
  input  logic [AW-1:0] iT2_LEN,
  input  logic [DW-1:0] iSRAM_DQ,
  output logic [AW-1:0] oSRAM_ADDR,
  output logic [DW-1:0] oSRAM_DQ,
  output logic          oSRAM_DQ_OE,
  output logic          oSRAM_WE_N,
  output logic          oSRAM_OE_N,
  output logic [DW-1:0] oT1_DATA,
  output logic [DW-1:0] oT2_DATA,
  output logic          oDATA_VALID,
  output logic          oBUSY,
  output logic          oDONE,
  output logic          oOVERRUN
);
  localparam int CW = $clog2(ACC_CYC);
  localparam logic [CW-1:0] LAST = CW'(ACC_CYC - 1);
  typedef enum logic [2:0] {IDLE, RD1, RD2, WR, ADV} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [AW-1:0] ptr1, ptr2, b1, b2, l1, l2;
  logic [DW-1:0] rec_data, sh1, sh2, rd1, rd2;
  logic done1, done2, rec_en, rec_trk, act1, act2, last_cnt, wr_go, end1, end2;
  assign act1 = (l1 != '0) && !done1;
  assign act2 = (l2 != '0) && !done2;
  assign last_cnt = cnt == LAST;
  assign wr_go = rec_en && (rec_trk ? act2 : act1);
  assign rd1 = act1 ? iSRAM_DQ : '0;
  assign rd2 = act2 ? iSRAM_DQ : '0;
  // end compare at AW+1 bits so base+len reaching 2^AW does not alias
  assign end1 = {1'b0, ptr1} == {1'b0, b1} + {1'b0, l1} - (AW+1)'(1);
  assign end2 = {1'b0, ptr2} == {1'b0, b2} + {1'b0, l2} - (AW+1)'(1);
  assign oSRAM_DQ = rec_data;
  assign oBUSY = state != IDLE;
  assign oDATA_VALID = state == ADV;
  assign oDONE = ((l1 != '0) || (l2 != '0)) && ((l1 == '0) || done1) && ((l2 == '0) || done2);
  always_comb begin
    nxt = state;
    oSRAM_ADDR = '0;
    oSRAM_OE_N = 1'b1;
    oSRAM_WE_N = 1'b1;
    oSRAM_DQ_OE = 1'b0;
    case (state)
      IDLE: nxt = (iFRAME && iRUN) ? RD1 : IDLE;
      RD1: begin
        oSRAM_ADDR = ptr1;
        oSRAM_OE_N = !act1;
        nxt = (!act1 || last_cnt) ? RD2 : RD1;
      end
      RD2: begin
        oSRAM_ADDR = ptr2;
        oSRAM_OE_N = !act2;
        nxt = (!act2 || last_cnt) ? (wr_go ? WR : ADV) : RD2;
      end
      WR: begin
        oSRAM_ADDR = rec_trk ? ptr2 : ptr1;
        oSRAM_DQ_OE = 1'b1;
        oSRAM_WE_N = last_cnt;
        nxt = last_cnt ? ADV : WR;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      cnt <= '0;
      ptr1 <= '0;
      ptr2 <= '0;
      b1 <= '0;
      b2 <= '0;
      l1 <= '0;
      l2 <= '0;
      done1 <= 1'b0;
      done2 <= 1'b0;
      rec_en <= 1'b0;
      rec_trk <= 1'b0;
      rec_data <= '0;
      sh1 <= '0;
      sh2 <= '0;
      oT1_DATA <= '0;
      oT2_DATA <= '0;
      oOVERRUN <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : cnt + CW'(1);
      oOVERRUN <= iFRAME && (state != IDLE);
      if (state == IDLE && iFRAME && iRUN) begin
        rec_data <= iREC_DATA;
        rec_en <= iREC_EN;
        rec_trk <= iREC_TRK;
      end
      // geometry is latched on rewind so mid-run register writes cannot corrupt the walk
      if (state == IDLE && !iRUN) begin
        ptr1 <= iT1_BASE;
        ptr2 <= iT2_BASE;
        b1 <= iT1_BASE;
        b2 <= iT2_BASE;
        l1 <= iT1_LEN;
        l2 <= iT2_LEN;
        done1 <= 1'b0;
        done2 <= 1'b0;
      end
      if (state == RD1 && nxt != RD1) sh1 <= rd1;
      if (state == RD2 && nxt != RD2) sh2 <= rd2;
      if (nxt == ADV) begin
        oT1_DATA <= sh1;
        oT2_DATA <= (state == RD2) ? rd2 : sh2;
      end
      if (state == ADV && act1) begin
        ptr1 <= end1 ? (iLOOP ? b1 : ptr1) : ptr1 + AW'(1);
        done1 <= end1 && !iLOOP;
      end
      if (state == ADV && act2) begin
        ptr2 <= end2 ? (iLOOP ? b2 : ptr2) : ptr2 + AW'(1);
        done2 <= end2 && !iLOOP;
      end
    end
  end
endmodule
